debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
Parametrised run-control and debug block for the CPU datapath. It generalises the single-address breakpoint and halt logic into:
- NUM_BP independent PC breakpoints
- one RAM-write watchpoint
- cycle-step and instruction-step modes
- saturating cycle and instruction counters

It drives the datapath halt line and feeds the 7-segment and debug ILA probes.

Parameters:
ADDR_WIDTH, 16, width of PC and RAM address
NUM_BP, 4, number of PC breakpoint channels (1..8)
CNT_WIDTH, 32, width of cycle/instruction counters
IDX_WIDTH, $clog2(NUM_BP+1), width of hit index (derived, not overridden)

Ports:
i_clk  in  1  system clock; all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_pc  in  ADDR_WIDTH  current program counter
i_instrFinishedN  in  1  low for one cycle on the last cycle of each instruction
i_bpAddr  in  NUM_BP*ADDR_WIDTH  breakpoint addresses; channel k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
i_bpEnable  in  NUM_BP  per-channel enable
i_wpAddr  in  ADDR_WIDTH  watchpoint RAM address
i_wpEnable  in  1  watchpoint enable
i_ramAddr  in  ADDR_WIDTH  current RAM address
i_ramNWE  in  1  RAM write strobe, active low
i_stepPulse  in  1  debounced single-cycle step/resume pulse
i_swStepNRun  in  1  1 = step mode, 0 = run mode
i_swInstrNCycle  in  1  1 = instruction step, 0 = cycle step
i_clrCounters  in  1  synchronous counter clear
o_halt  out  1  1 = datapath clock gated
o_hitN  out  1  sticky hit flag, active low
o_hitIndex  out  IDX_WIDTH  0..NUM_BP-1 = breakpoint channel; NUM_BP = watchpoint
o_cycleCount  out  CNT_WIDTH  count of non-halted cycles
o_instrCount  out  CNT_WIDTH  count of completed instructions
o_state  out  2  FSM state, for ILA/display

Behaviour:
- Reset values:
  - state HALTED (2'd1), o_halt=1
  - o_hitN=1, o_hitIndex=0
  - both counters 0, skipBp=0, wpPending=0
- States: RUN=0, HALTED=1, STEP_CYC=2, STEP_INSTR=3. o_halt = (state==HALTED).
- bpMatch: any k with i_bpEnable[k] && i_pc==bpAddr[k], evaluated only when i_instrFinishedN==0. Lowest k wins.
- wpMatch: i_wpEnable && !i_ramNWE && i_ramAddr==i_wpAddr, evaluated in any non-halted state.
  - Sets wpPending.
  - The hit is taken at the next instruction boundary, which may be the same cycle if i_instrFinishedN==0.
- hit = (bpMatch && !skipBp) || wpPending || wpMatch, qualified by i_instrFinishedN==0.
  - If both a breakpoint and the watchpoint hit, the breakpoint index is reported.
- RUN:
  - hit -> HALTED next cycle; o_hitN<=0; o_hitIndex latched; wpPending cleared.
  - else if i_swStepNRun==1 and i_instrFinishedN==0 -> HALTED (switching to step mode halts at the next boundary).
- HALTED:
  - i_stepPulse with i_swStepNRun==1 and i_swInstrNCycle==0 -> STEP_CYC.
  - i_stepPulse with i_swStepNRun==1 and i_swInstrNCycle==1 -> STEP_INSTR.
  - i_stepPulse with i_swStepNRun==0 -> RUN.
  - Every exit clears o_hitN to 1 and sets skipBp=1.
  - With no pulse, i_swStepNRun==0 and o_hitN==1 -> RUN. This is the auto-run path after reset; a sticky hit always requires a pulse.
- STEP_CYC: exactly one non-halted cycle, then HALTED. A hit in that cycle still latches o_hitN/o_hitIndex.
- STEP_INSTR: stays until i_instrFinishedN==0, then HALTED next cycle. A hit latches as in RUN.
- skipBp: cleared on the first i_instrFinishedN==0 cycle after leaving HALTED. This stops a breakpoint at the resumed PC from re-firing immediately. The watchpoint is not masked.
- Counters:
  - o_cycleCount +1 each cycle with o_halt==0.
  - o_instrCount +1 each cycle with o_halt==0 && i_instrFinishedN==0.
  - Both saturate at all-ones; no wrap.
  - i_clrCounters has priority over increment.
- i_stepPulse while not HALTED is ignored.
- Asynchronous reset mid-step forces HALTED immediately and discards pending hits.

Test Plan:
1. Reset, run mode, bp0=0x0010 enabled, PC advances with i_instrFinishedN pulses -> o_halt=1 the cycle after the boundary at PC=0x0010; o_hitN=0; o_hitIndex=0; o_instrCount = number of boundaries seen.
2. bp1=bp3=0x0020 both enabled -> hit at 0x0020 reports o_hitIndex=1. Then i_stepPulse -> RUN, no re-hit at 0x0020, next hit on the following pass.
3. Watchpoint 0x8005, RAM write to 0x8005 mid-instruction -> halt one cycle after that instruction's boundary; o_hitIndex=NUM_BP (4).
4. Step mode, cycle step: three i_stepPulse -> o_cycleCount +3 exactly, o_halt low one cycle each. Instruction step with a 5-cycle instruction -> o_cycleCount +5, o_instrCount +1.
5. Counter saturation with CNT_WIDTH=4: 20 running cycles -> o_cycleCount=15. i_clrCounters together with increment -> 0.
6. Assert i_reset during STEP_INSTR and during a pending watchpoint -> o_halt=1 immediately, o_hitN=1, counters 0; after release in run mode -> RUN with no spurious hit.

Source files
------------

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
//
// Run-control and debug block for the CPU datapath. It gates the datapath
// clock (o_halt) on PC breakpoints, on a RAM-write watchpoint, in cycle-step
// and instruction-step modes, and keeps saturating cycle/instruction counters
// for the display and ILA probes.
//
// Ports:
//   i_clk            system clock, all state on rising edge
//   i_reset          asynchronous active-high reset
//   i_pc             current program counter
//   i_instrFinishedN low on the last cycle of every instruction (boundary)
//   i_bpAddr         packed breakpoint addresses, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_bpEnable       per-channel breakpoint enable
//   i_wpAddr         watchpoint RAM address
//   i_wpEnable       watchpoint enable
//   i_ramAddr        current RAM address
//   i_ramNWE         RAM write strobe, active low
//   i_stepPulse      single-cycle step/resume pulse
//   i_swStepNRun     1 = step mode, 0 = run mode
//   i_swInstrNCycle  1 = instruction step, 0 = cycle step
//   i_clrCounters    synchronous counter clear
//   o_halt           1 = datapath clock gated
//   o_hitN           sticky hit flag, active low
//   o_hitIndex       breakpoint channel of the last hit, NUM_BP = watchpoint
//   o_cycleCount     number of non-halted cycles (saturating)
//   o_instrCount     number of completed instructions (saturating)
//   o_state          FSM state for ILA/display
// -----------------------------------------------------------------------------
module debug_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_BP     = 4,
    parameter int CNT_WIDTH  = 32,
    localparam int IDX_WIDTH = $clog2(NUM_BP + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [ADDR_WIDTH-1:0]        i_pc,
    input  logic                         i_instrFinishedN,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] i_bpAddr,
    input  logic [NUM_BP-1:0]            i_bpEnable,
    input  logic [ADDR_WIDTH-1:0]        i_wpAddr,
    input  logic                         i_wpEnable,
    input  logic [ADDR_WIDTH-1:0]        i_ramAddr,
    input  logic                         i_ramNWE,
    input  logic                         i_stepPulse,
    input  logic                         i_swStepNRun,
    input  logic                         i_swInstrNCycle,
    input  logic                         i_clrCounters,
    output logic                         o_halt,
    output logic                         o_hitN,
    output logic [IDX_WIDTH-1:0]         o_hitIndex,
    output logic [CNT_WIDTH-1:0]         o_cycleCount,
    output logic [CNT_WIDTH-1:0]         o_instrCount,
    output logic [1:0]                   o_state
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALTED     = 2'd1,
        STEP_CYC   = 2'd2,
        STEP_INSTR = 2'd3
    } state_t;

    localparam logic [IDX_WIDTH-1:0] WP_INDEX = IDX_WIDTH'(NUM_BP);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 stateNext_s;
    logic                   halt_r;
    logic                   hitN_r;
    logic                   hitNNext_s;
    logic [IDX_WIDTH-1:0]   hitIndex_r;
    logic [IDX_WIDTH-1:0]   hitIndexNext_s;
    logic                   skipBp_r;
    logic                   skipBpNext_s;
    logic                   wpPending_r;
    logic                   wpPendingNext_s;
    logic [CNT_WIDTH-1:0]   cycleCount_r;
    logic [CNT_WIDTH-1:0]   instrCount_r;

    logic                   boundary_s;
    logic                   running_s;
    logic                   bpMatch_s;
    logic [IDX_WIDTH-1:0]   bpIdx_s;
    logic                   bpTake_s;
    logic                   wpMatch_s;
    logic                   hit_s;

    assign boundary_s = ~i_instrFinishedN;
    assign running_s  = (state_r != HALTED);

    // Breakpoint comparators; scanning high-to-low leaves the lowest matching channel
    always_comb begin
        bpMatch_s = 1'b0;
        bpIdx_s   = {IDX_WIDTH{1'b0}};
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (boundary_s && i_bpEnable[k] &&
                (i_pc == i_bpAddr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                bpMatch_s = 1'b1;
                bpIdx_s   = IDX_WIDTH'(k);
            end else begin
                bpMatch_s = bpMatch_s;
                bpIdx_s   = bpIdx_s;
            end
        end
    end

    // A breakpoint at the PC we just resumed from is masked until the first boundary;
    // the watchpoint is never masked and a write landing on the boundary cycle counts.
    assign bpTake_s  = bpMatch_s && !skipBp_r;
    assign wpMatch_s = running_s && i_wpEnable && !i_ramNWE && (i_ramAddr == i_wpAddr);
    assign hit_s     = running_s && boundary_s && (bpTake_s || wpPending_r || wpMatch_s);

    // Next-state and hit-bookkeeping logic for the run-control FSM
    always_comb begin
        stateNext_s     = state_r;
        hitNNext_s      = hitN_r;
        hitIndexNext_s  = hitIndex_r;
        skipBpNext_s    = skipBp_r;
        wpPendingNext_s = wpPending_r;

        if (running_s) begin
            if (wpMatch_s) begin
                wpPendingNext_s = 1'b1;
            end else begin
                wpPendingNext_s = wpPending_r;
            end
            if (boundary_s) begin
                skipBpNext_s = 1'b0;
            end else begin
                skipBpNext_s = skipBp_r;
            end
            // A hit latches in every non-halted state; the pending write is consumed.
            if (hit_s) begin
                hitNNext_s      = 1'b0;
                hitIndexNext_s  = bpTake_s ? bpIdx_s : WP_INDEX;
                wpPendingNext_s = 1'b0;
            end else begin
                hitNNext_s     = hitN_r;
                hitIndexNext_s = hitIndex_r;
            end
        end else begin
            skipBpNext_s    = skipBp_r;
            wpPendingNext_s = wpPending_r;
        end

        case (state_r)
            RUN: begin
                if (hit_s) begin
                    stateNext_s = HALTED;
                end else if (i_swStepNRun && boundary_s) begin
                    stateNext_s = HALTED;
                end else begin
                    stateNext_s = RUN;
                end
            end
            HALTED: begin
                if (i_stepPulse) begin
                    if (!i_swStepNRun) begin
                        stateNext_s = RUN;
                    end else if (i_swInstrNCycle) begin
                        stateNext_s = STEP_INSTR;
                    end else begin
                        stateNext_s = STEP_CYC;
                    end
                    hitNNext_s   = 1'b1;
                    skipBpNext_s = 1'b1;
                end else if (!i_swStepNRun && hitN_r) begin
                    // Auto-run after reset; a sticky hit needs an explicit pulse.
                    stateNext_s  = RUN;
                    hitNNext_s   = 1'b1;
                    skipBpNext_s = 1'b1;
                end else begin
                    stateNext_s = HALTED;
                end
            end
            STEP_CYC: begin
                stateNext_s = HALTED;
            end
            STEP_INSTR: begin
                if (boundary_s) begin
                    stateNext_s = HALTED;
                end else begin
                    stateNext_s = STEP_INSTR;
                end
            end
            default: begin
                stateNext_s = HALTED;
            end
        endcase
    end

    // Run-control state registers; halt is registered from the next state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= HALTED;
            halt_r      <= 1'b1;
            hitN_r      <= 1'b1;
            hitIndex_r  <= {IDX_WIDTH{1'b0}};
            skipBp_r    <= 1'b0;
            wpPending_r <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            halt_r      <= (stateNext_s == HALTED);
            hitN_r      <= hitNNext_s;
            hitIndex_r  <= hitIndexNext_s;
            skipBp_r    <= skipBpNext_s;
            wpPending_r <= wpPendingNext_s;
        end
    end

    // Saturating cycle and instruction counters; clear wins over increment
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycleCount_r <= {CNT_WIDTH{1'b0}};
            instrCount_r <= {CNT_WIDTH{1'b0}};
        end else if (i_clrCounters) begin
            cycleCount_r <= {CNT_WIDTH{1'b0}};
            instrCount_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (!halt_r && (cycleCount_r != CNT_MAX)) begin
                cycleCount_r <= cycleCount_r + CNT_ONE;
            end else begin
                cycleCount_r <= cycleCount_r;
            end
            if (!halt_r && boundary_s && (instrCount_r != CNT_MAX)) begin
                instrCount_r <= instrCount_r + CNT_ONE;
            end else begin
                instrCount_r <= instrCount_r;
            end
        end
    end

    assign o_halt       = halt_r;
    assign o_hitN       = hitN_r;
    assign o_hitIndex   = hitIndex_r;
    assign o_cycleCount = cycleCount_r;
    assign o_instrCount = instrCount_r;
    assign o_state      = state_r;

endmodule

// File: tb/tb_debug_unit.sv
module tb_debug_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        ifn;
    logic [63:0] bpAddr;
    logic [3:0]  bpEn;
    logic [15:0] wpAddr;
    logic        wpEn;
    logic [15:0] ramAddr;
    logic        ramNWE;
    logic        stepPulse;
    logic        swStep;
    logic        swInstr;
    logic        clr;
    logic        halt;
    logic        hitN;
    logic [2:0]  hitIdx;
    logic [31:0] cycCnt;
    logic [31:0] insCnt;
    logic [1:0]  state;

    // Second instance with 4-bit counters for the saturation checks
    logic        rst2;
    logic        clr2;
    logic        halt2;
    logic        hitN2;
    logic [2:0]  hitIdx2;
    logic [3:0]  cycCnt2;
    logic [3:0]  insCnt2;
    logic [1:0]  state2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    debug_unit #(.ADDR_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_pc(pc), .i_instrFinishedN(ifn),
        .i_bpAddr(bpAddr), .i_bpEnable(bpEn), .i_wpAddr(wpAddr), .i_wpEnable(wpEn),
        .i_ramAddr(ramAddr), .i_ramNWE(ramNWE), .i_stepPulse(stepPulse),
        .i_swStepNRun(swStep), .i_swInstrNCycle(swInstr), .i_clrCounters(clr),
        .o_halt(halt), .o_hitN(hitN), .o_hitIndex(hitIdx),
        .o_cycleCount(cycCnt), .o_instrCount(insCnt), .o_state(state)
    );

    debug_unit #(.ADDR_WIDTH(16), .NUM_BP(4), .CNT_WIDTH(4)) dut2 (
        .i_clk(clk), .i_reset(rst2), .i_pc(16'h0000), .i_instrFinishedN(1'b0),
        .i_bpAddr(64'h0), .i_bpEnable(4'b0000), .i_wpAddr(16'h0000), .i_wpEnable(1'b0),
        .i_ramAddr(16'h0000), .i_ramNWE(1'b1), .i_stepPulse(1'b0),
        .i_swStepNRun(1'b0), .i_swInstrNCycle(1'b0), .i_clrCounters(clr2),
        .o_halt(halt2), .o_hitN(hitN2), .o_hitIndex(hitIdx2),
        .o_cycleCount(cycCnt2), .o_instrCount(insCnt2), .o_state(state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [15:0] addr, input int n);
        pc = addr;
        for (int c = 0; c < n; c++) begin
            ifn = (c == n - 1) ? 1'b0 : 1'b1;
            tick();
        end
        ifn = 1'b1;
    endtask

    task automatic pulse();
        stepPulse = 1'b1;
        tick();
        stepPulse = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1; clr2 = 1'b0;
        pc = 16'h0000; ifn = 1'b1;
        bpAddr = {16'h0020, 16'h0030, 16'h0020, 16'h0010};
        bpEn = 4'b0000; wpAddr = 16'h8005; wpEn = 1'b0;
        ramAddr = 16'h0000; ramNWE = 1'b1; stepPulse = 1'b0;
        swStep = 1'b0; swInstr = 1'b0; clr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_halt", 32'(halt), 32'd1);
        check("rst_hitN", 32'(hitN), 32'd1);
        check("rst_idx", 32'(hitIdx), 32'd0);
        check("rst_cyc", cycCnt, 32'd0);
        check("rst_ins", insCnt, 32'd0);
        check("rst_state", 32'(state), 32'd1);

        // 1: single breakpoint at 0x0010 in run mode
        bpEn = 4'b0001;
        rst = 1'b0;
        tick();
        check("t1_autorun_state", 32'(state), 32'd0);
        check("t1_autorun_halt", 32'(halt), 32'd0);
        instr(16'h0000, 2);
        instr(16'h0004, 2);
        instr(16'h0008, 2);
        instr(16'h000C, 2);
        check("t1_running", 32'(halt), 32'd0);
        instr(16'h0010, 2);
        check("t1_halt", 32'(halt), 32'd1);
        check("t1_hitN", 32'(hitN), 32'd0);
        check("t1_idx", 32'(hitIdx), 32'd0);
        check("t1_ins", insCnt, 32'd5);
        check("t1_cyc", cycCnt, 32'd10);
        repeat (3) tick();
        check("t1_sticky_halt", 32'(halt), 32'd1);
        check("t1_frozen_cyc", cycCnt, 32'd10);

        // 2: two channels at 0x0020, lowest wins; resume skips the same PC once
        bpEn = 4'b1010;
        pulse();
        check("t2_resume_state", 32'(state), 32'd0);
        check("t2_resume_hitN", 32'(hitN), 32'd1);
        instr(16'h0014, 2);
        instr(16'h0018, 2);
        instr(16'h001C, 2);
        instr(16'h0020, 2);
        check("t2_halt", 32'(halt), 32'd1);
        check("t2_idx", 32'(hitIdx), 32'd1);
        check("t2_hitN", 32'(hitN), 32'd0);
        pulse();
        instr(16'h0020, 2);
        check("t2_no_rehit_halt", 32'(halt), 32'd0);
        check("t2_no_rehit_hitN", 32'(hitN), 32'd1);
        instr(16'h0024, 2);
        instr(16'h0020, 2);
        check("t2_second_pass_halt", 32'(halt), 32'd1);
        check("t2_second_pass_idx", 32'(hitIdx), 32'd1);

        // 3: watchpoint write mid-instruction halts after that instruction's boundary
        bpEn = 4'b0000; wpEn = 1'b1;
        pulse();
        pc = 16'h0030; ifn = 1'b1;
        tick();
        ramAddr = 16'h8005; ramNWE = 1'b0;
        tick();
        ramNWE = 1'b1; ramAddr = 16'h0000;
        tick();
        check("t3_pending_halt", 32'(halt), 32'd0);
        check("t3_pending_hitN", 32'(hitN), 32'd1);
        ifn = 1'b0;
        tick();
        ifn = 1'b1;
        check("t3_halt", 32'(halt), 32'd1);
        check("t3_hitN", 32'(hitN), 32'd0);
        check("t3_idx", 32'(hitIdx), 32'd4);
        wpEn = 1'b0;

        // 4: cycle step x3 then one 5-cycle instruction step
        swStep = 1'b1; swInstr = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_cyc", cycCnt, 32'd0);
        check("t4_clr_ins", insCnt, 32'd0);
        for (int s = 0; s < 3; s++) begin
            pulse();
            check("t4_step_run", 32'(halt), 32'd0);
            check("t4_step_state", 32'(state), 32'd2);
            tick();
            check("t4_step_back", 32'(halt), 32'd1);
        end
        check("t4_cyc3", cycCnt, 32'd3);
        check("t4_ins0", insCnt, 32'd0);
        swInstr = 1'b1;
        pulse();
        repeat (4) tick();
        check("t4_instr_state", 32'(state), 32'd3);
        check("t4_instr_run", 32'(halt), 32'd0);
        ifn = 1'b0;
        tick();
        ifn = 1'b1;
        check("t4_instr_halt", 32'(halt), 32'd1);
        check("t4_instr_cyc", cycCnt, 32'd8);
        check("t4_instr_ins", insCnt, 32'd1);

        // 5: 4-bit counters saturate; clear beats increment
        check("t5_rst_cyc", 32'(cycCnt2), 32'd0);
        rst2 = 1'b0;
        tick();
        repeat (20) tick();
        check("t5_sat_cyc", 32'(cycCnt2), 32'd15);
        check("t5_sat_ins", 32'(insCnt2), 32'd15);
        clr2 = 1'b1;
        tick();
        check("t5_clr_cyc", 32'(cycCnt2), 32'd0);
        check("t5_clr_ins", 32'(insCnt2), 32'd0);
        clr2 = 1'b0;
        tick();
        check("t5_restart_cyc", 32'(cycCnt2), 32'd1);

        // 6a: reset during an instruction step
        pulse();
        tick();
        check("t6_in_step", 32'(state), 32'd3);
        rst = 1'b1;
        #1;
        check("t6a_halt", 32'(halt), 32'd1);
        check("t6a_state", 32'(state), 32'd1);
        check("t6a_cyc", cycCnt, 32'd0);
        check("t6a_ins", insCnt, 32'd0);
        swStep = 1'b0; swInstr = 1'b0; wpEn = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6a_autorun", 32'(state), 32'd0);

        // 6b: reset while a watchpoint hit is pending
        pc = 16'h0040; ifn = 1'b1;
        ramAddr = 16'h8005; ramNWE = 1'b0;
        tick();
        ramNWE = 1'b1; ramAddr = 16'h0000;
        tick();
        check("t6b_pending_run", 32'(halt), 32'd0);
        rst = 1'b1;
        #1;
        check("t6b_halt", 32'(halt), 32'd1);
        check("t6b_hitN", 32'(hitN), 32'd1);
        check("t6b_cyc", cycCnt, 32'd0);
        rst = 1'b0;
        tick();
        instr(16'h0044, 2);
        instr(16'h0048, 2);
        check("t6b_no_hit_halt", 32'(halt), 32'd0);
        check("t6b_no_hit_hitN", 32'(hitN), 32'd1);
        check("t6b_state", 32'(state), 32'd0);
        check("t6b_cyc", cycCnt, 32'd4);
        check("t6b_ins", insCnt, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
